// File: rtl/display_value_bcd.sv
// Snapshots four 8-bit display values on frame_start and converts them to 3-digit BCD by double dabble.
// Latency 41 cycles frame_start->outputs; frame_start while busy is dropped; outputs commit together.
module display_value_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [7:0]  countdown_sec,
  input  logic [7:0]  green_duration,
  input  logic [7:0]  yellow_duration,
  input  logic [7:0]  red_holding,
  output logic [11:0] countdown_bcd,
  output logic [11:0] green_bcd,
  output logic [11:0] yellow_bcd,
  output logic [11:0] red_bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    COMMIT
  } state_t;

  state_t            state;
  logic [3:0][7:0]   snap;
  logic [3:0][11:0]  staging;
  logic [19:0]       sr;
  logic [19:0]       sr_adj;
  logic [2:0]        iter;
  logic [1:0]        ch;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Only the three BCD nibbles are corrected; the binary tail shifts through untouched.
  always_comb begin
    sr_adj        = sr;
    sr_adj[19:16] = add3(sr[19:16]);
    sr_adj[15:12] = add3(sr[15:12]);
    sr_adj[11:8]  = add3(sr[11:8]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      snap          <= '0;
      staging       <= '0;
      sr            <= '0;
      iter          <= '0;
      ch            <= '0;
      countdown_bcd <= '0;
      green_bcd     <= '0;
      yellow_bcd    <= '0;
      red_bcd       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap  <= {red_holding, yellow_duration, green_duration, countdown_sec};
            ch    <= 2'd0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          sr    <= {12'b0, snap[ch]};
          iter  <= 3'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          sr   <= sr_adj << 1;
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= STORE;
        end
        STORE: begin
          staging[ch] <= sr[19:8];
          if (ch == 2'd3) begin
            state <= COMMIT;
          end else begin
            ch    <= ch + 2'd1;
            state <= LOAD;
          end
        end
        COMMIT: begin
          countdown_bcd <= staging[0];
          green_bcd     <= staging[1];
          yellow_bcd    <= staging[2];
          red_bcd       <= staging[3];
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_value_bcd.sv
// Randomized bench for display_value_bcd against an arithmetic decimal-digit model.
module tb_display_value_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [7:0]  countdown_sec, green_duration, yellow_duration, red_holding;
  logic [11:0] countdown_bcd, green_bcd, yellow_bcd, red_bcd;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  display_value_bcd dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .countdown_sec  (countdown_sec),
    .green_duration (green_duration),
    .yellow_duration(yellow_duration),
    .red_holding    (red_holding),
    .countdown_bcd  (countdown_bcd),
    .green_bcd      (green_bcd),
    .yellow_bcd     (yellow_bcd),
    .red_bcd        (red_bcd),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    int r;
    r = (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    return r[11:0];
  endfunction

  function automatic logic [47:0] ref_all(input int a, input int b, input int c, input int d);
    return {ref_bcd(a), ref_bcd(b), ref_bcd(c), ref_bcd(d)};
  endfunction

  // Leaves the bench at the falling edge right after the edge that sampled frame_start.
  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic set_inputs(input int a, input int b, input int c, input int d);
    countdown_sec   = a[7:0];
    green_duration  = b[7:0];
    yellow_duration = c[7:0];
    red_holding     = d[7:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_start = 1'b0;
    set_inputs(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== 48'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_frame();
    int bcnt, dcnt, dat;
    bcnt = 0; dcnt = 0; dat = -1;
    set_inputs(0, 0, 0, 0);
    pulse_frame();
    for (int k = 0; k <= 45; k++) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin dcnt++; dat = k; end
      @(negedge clk);
    end
    n_cmp++; if (bcnt != 41) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d want 41", bcnt); end
    n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", dcnt); end
    n_cmp++; if (dat != 41) begin n_bad++; $display("FAIL zero_done_edge: got %0d want 41", dat); end
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== 48'h0) begin
      n_bad++; $display("FAIL zero_outputs: got %h want 0", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}); end
  endtask

  task automatic test_known();
    set_inputs(255, 9, 100, 37);
    pulse_frame();
    repeat (40) @(negedge clk);
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== 48'h0) begin
      n_bad++; $display("FAIL known_before_e41: got %h want 0", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL known_done_early: got %b want 0", done); end
    @(negedge clk);
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== {12'h255, 12'h009, 12'h100, 12'h037}) begin
      n_bad++; $display("FAIL known_e41: got %h want 255009100037", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL known_done_e41: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL known_done_e42: got %b want 0", done); end
  endtask

  task automatic test_sweep();
    int a, b, c, d, cyc;
    logic [47:0] got, exp;
    logic bad_nib;
    for (int i = 0; i < 256; i++) begin
      a = i; b = 255 - i; c = (i + 85) % 256; d = (i * 37 + 11) % 256;
      set_inputs(a, b, c, d);
      pulse_frame();
      wait_done(cyc);
      got = {countdown_bcd, green_bcd, yellow_bcd, red_bcd};
      exp = ref_all(a, b, c, d);
      n_cmp++; if (cyc != 41) begin n_bad++; $display("FAIL sweep_latency[%0d]: got %0d want 41", i, cyc); end
      n_cmp++; if (got[47:36] !== exp[47:36]) begin n_bad++; $display("FAIL sweep_countdown[%0d]: got %h want %h", a, got[47:36], exp[47:36]); end
      n_cmp++; if (got[35:24] !== exp[35:24]) begin n_bad++; $display("FAIL sweep_green[%0d]: got %h want %h", b, got[35:24], exp[35:24]); end
      n_cmp++; if (got[23:12] !== exp[23:12]) begin n_bad++; $display("FAIL sweep_yellow[%0d]: got %h want %h", c, got[23:12], exp[23:12]); end
      n_cmp++; if (got[11:0] !== exp[11:0]) begin n_bad++; $display("FAIL sweep_red[%0d]: got %h want %h", d, got[11:0], exp[11:0]); end
      bad_nib = 1'b0;
      for (int j = 0; j < 12; j++) if (got[j*4 +: 4] > 4'd9) bad_nib = 1'b1;
      n_cmp++; if (bad_nib !== 1'b0) begin n_bad++; $display("FAIL sweep_nibble_range[%0d]: got %h want all digits <=9", i, got); end
    end
  endtask

  task automatic test_random();
    int a, b, c, d, cyc;
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      c = $urandom_range(0, 255); d = $urandom_range(0, 255);
      set_inputs(a, b, c, d);
      pulse_frame();
      wait_done(cyc);
      n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== ref_all(a, b, c, d)) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, {countdown_bcd, green_bcd, yellow_bcd, red_bcd}, ref_all(a, b, c, d)); end
    end
  endtask

  task automatic test_snapshot();
    int cyc;
    set_inputs(30, 1, 2, 3);
    pulse_frame();
    repeat (4) @(negedge clk);
    countdown_sec = 8'd29;
    wait_done(cyc);
    n_cmp++; if (countdown_bcd !== 12'h030) begin n_bad++; $display("FAIL snapshot_first: got %h want 030", countdown_bcd); end
    pulse_frame();
    wait_done(cyc);
    n_cmp++; if (countdown_bcd !== 12'h029) begin n_bad++; $display("FAIL snapshot_second: got %h want 029", countdown_bcd); end
  endtask

  task automatic test_busy_reject();
    int a, b, c, d, dcnt, dk;
    logic [47:0] cap;
    a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    c = $urandom_range(0, 255); d = $urandom_range(0, 255);
    set_inputs(a, b, c, d);
    pulse_frame();
    repeat (19) @(negedge clk);
    set_inputs((a + 1) % 256, (b + 1) % 256, (c + 1) % 256, (d + 1) % 256);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    dcnt = 0; dk = -1; cap = '0;
    for (int k = 20; k <= 90; k++) begin
      if (done === 1'b1) begin dcnt++; dk = k; cap = {countdown_bcd, green_bcd, yellow_bcd, red_bcd}; end
      @(negedge clk);
    end
    n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL reject_done_count: got %0d want 1", dcnt); end
    n_cmp++; if (dk != 41) begin n_bad++; $display("FAIL reject_done_edge: got %0d want 41", dk); end
    n_cmp++; if (cap !== ref_all(a, b, c, d)) begin n_bad++; $display("FAIL reject_values: got %h want %h", cap, ref_all(a, b, c, d)); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reject_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int cyc, dcnt, bcnt, a, b, c, d;
    set_inputs(255, 255, 255, 255);
    pulse_frame();
    wait_done(cyc);
    n_cmp++; if (countdown_bcd !== 12'h255) begin n_bad++; $display("FAIL midreset_setup: got %h want 255", countdown_bcd); end
    set_inputs(7, 8, 9, 10);
    pulse_frame();
    repeat (24) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== 48'h0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h want 0", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    reset = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    n_cmp++; if (dcnt != 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d want 0", dcnt); end
    n_cmp++; if (bcnt != 0) begin n_bad++; $display("FAIL midreset_no_busy: got %0d want 0", bcnt); end
    a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    c = $urandom_range(0, 255); d = $urandom_range(0, 255);
    set_inputs(a, b, c, d);
    pulse_frame();
    wait_done(cyc);
    n_cmp++; if (cyc != 41) begin n_bad++; $display("FAIL midreset_fresh_latency: got %0d want 41", cyc); end
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== ref_all(a, b, c, d)) begin
      n_bad++; $display("FAIL midreset_fresh_values: got %h want %h", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}, ref_all(a, b, c, d)); end
  endtask

  task automatic test_reset_vs_frame();
    int dcnt, bcnt;
    set_inputs(123, 45, 67, 89);
    @(negedge clk);
    reset = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_start = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    n_cmp++; if (bcnt != 0) begin n_bad++; $display("FAIL reset_wins_busy: got %0d want 0", bcnt); end
    n_cmp++; if (dcnt != 0) begin n_bad++; $display("FAIL reset_wins_done: got %0d want 0", dcnt); end
    n_cmp++; if ({countdown_bcd, green_bcd, yellow_bcd, red_bcd} !== 48'h0) begin
      n_bad++; $display("FAIL reset_wins_outputs: got %h want 0", {countdown_bcd, green_bcd, yellow_bcd, red_bcd}); end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    set_inputs(0, 0, 0, 0);
    test_reset();
    test_zero_frame();
    test_known();
    test_sweep();
    test_random();
    test_snapshot();
    test_busy_reject();
    test_mid_reset();
    test_reset_vs_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
